alu: RTL and testbench

- Parameterised integer ALU; MIPS R-type funct-field opcodes (6 bits) select one of eight operations on two N_BITS operands.
- Result and status flags are registered: one-cycle latency, valid-qualified.
- Sits in the datapath execute stage, fed by operand registers or switches, driving result/flag consumers.

---
 rtl/alu.sv | 110 +++++++++++
 tb/tb_alu.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/alu.sv
// Registered integer ALU with MIPS R-type funct opcodes, one-cycle latency.
// Status flags (zero/negative/carry/overflow/illegal_op) exist only when ALU_FLAGS_EN is defined.
module alu #(
  parameter int N_BITS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [N_BITS-1:0] d0,
  input  logic [N_BITS-1:0] d1,
  input  logic [5:0]        opcode,
  output logic [N_BITS-1:0] out,
  output logic              out_valid,
  output logic              zero,
  output logic              negative,
  output logic              carry,
  output logic              overflow,
  output logic              illegal_op
);

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;

  localparam int                MSB   = N_BITS - 1;
  localparam logic [N_BITS:0]   NB_W  = (N_BITS + 1)'(N_BITS);

  logic [N_BITS-1:0] sum, diff, res;
  logic              sh_big, is_add, is_sub, legal;

  // Shift amount is the whole of d1, so anything >= N_BITS saturates.
  assign sh_big = ({1'b0, d1} >= NB_W);
  assign sum    = d0 + d1;
  assign diff   = d0 - d1;

  always_comb begin
    res    = '0;
    legal  = 1'b1;
    is_add = 1'b0;
    is_sub = 1'b0;
    case (opcode)
      OP_ADD: begin res = sum;  is_add = 1'b1; end
      OP_SUB: begin res = diff; is_sub = 1'b1; end
      OP_AND: res = d0 & d1;
      OP_OR:  res = d0 | d1;
      OP_XOR: res = d0 ^ d1;
      OP_NOR: res = ~(d0 | d1);
      OP_SRA: res = sh_big ? {N_BITS{d0[MSB]}} : N_BITS'($signed(d0) >>> d1);
      OP_SRL: res = sh_big ? '0 : (d0 >> d1);
      default: legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) out <= res;
    end
  end

`ifdef ALU_FLAGS_EN
  logic cy_n, ov_n;

  // Carry-out of an N-bit add shows up as the wrapped sum being below an operand.
  always_comb begin
    cy_n = 1'b0;
    ov_n = 1'b0;
    if (is_add) begin
      cy_n = (sum < d0);
      ov_n = (d0[MSB] == d1[MSB]) && (sum[MSB] != d0[MSB]);
    end else if (is_sub) begin
      cy_n = (d0 < d1);
      ov_n = (d0[MSB] != d1[MSB]) && (diff[MSB] != d0[MSB]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zero       <= 1'b0;
      negative   <= 1'b0;
      carry      <= 1'b0;
      overflow   <= 1'b0;
      illegal_op <= 1'b0;
    end else if (in_valid) begin
      zero       <= (res == '0);
      negative   <= res[MSB];
      carry      <= cy_n;
      overflow   <= ov_n;
      illegal_op <= ~legal;
    end
  end
`else
  logic unused_flags;
  assign unused_flags = ^{is_add, is_sub, legal};
  assign zero       = 1'b0;
  assign negative   = 1'b0;
  assign carry      = 1'b0;
  assign overflow   = 1'b0;
  assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu (N_BITS=8): stimulus pushes expected results, a negedge monitor pops on out_valid.
// Flag expectations collapse to 0 when ALU_FLAGS_EN is not defined.
module tb_alu;

  localparam int N = 8;

  typedef struct {
    logic [7:0] res;
    logic       z, n, c, v, ill;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [N-1:0] d0, d1;
  logic [5:0]   opcode;
  logic [N-1:0] out;
  logic         out_valid, zero, negative, carry, overflow, illegal_op;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam logic [5:0] ADD = 6'b100000, SUB = 6'b100010, AND_ = 6'b100100, OR_ = 6'b100101,
                         XOR_ = 6'b100110, NOR_ = 6'b100111, SRA = 6'b000011, SRL = 6'b000010,
                         BAD = 6'b111111;

  alu #(.N_BITS(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .d0(d0), .d1(d1), .opcode(opcode),
    .out(out), .out_valid(out_valid), .zero(zero), .negative(negative), .carry(carry),
    .overflow(overflow), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  function automatic logic fl(input logic x);
`ifdef ALU_FLAGS_EN
    return x;
`else
    return 1'b0 & x;
`endif
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic issue(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] r, input logic z, input logic n, input logic c,
                       input logic v, input logic ill);
    exp_t e;
    e.res = r; e.z = fl(z); e.n = fl(n); e.c = fl(c); e.v = fl(v); e.ill = fl(ill);
    opcode = op; d0 = a; d1 = b; in_valid = 1'b1;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      in_valid = 1'b0;
      d0 = 8'($urandom); d1 = 8'($urandom); opcode = 6'($urandom);
      @(posedge clk); #1;
    end
  endtask

  // Monitor: every valid output must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_out_valid", 8'(out_valid), 8'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("out",        out,             e.res);
        check("zero",       8'(zero),        8'(e.z));
        check("negative",   8'(negative),    8'(e.n));
        check("carry",      8'(carry),       8'(e.c));
        check("overflow",   8'(overflow),    8'(e.v));
        check("illegal_op", 8'(illegal_op),  8'(e.ill));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; d0 = '0; d1 = '0; opcode = '0;
    @(posedge clk); @(posedge clk); #1;
    check("reset_out",       out,            8'h00);
    check("reset_out_valid", 8'(out_valid),  8'h00);
    rst = 1'b0;

    //          op    d0     d1     res    z  n  c  v  ill
    issue(ADD,  8'd100, 8'd27,  8'd127, 0, 0, 0, 0, 0);
    issue(ADD,  8'd200, 8'd100, 8'd44,  0, 0, 1, 0, 0);
    issue(ADD,  8'd100, 8'd100, 8'd200, 0, 1, 0, 1, 0);
    issue(ADD,  8'hFF,  8'h01,  8'h00,  1, 0, 1, 0, 0);
    issue(SUB,  8'd5,   8'd9,   8'd252, 0, 1, 1, 0, 0);
    issue(SUB,  8'd9,   8'd9,   8'd0,   1, 0, 0, 0, 0);
    issue(SUB,  8'h80,  8'h01,  8'h7F,  0, 0, 0, 1, 0);
    issue(AND_, 8'h0F,  8'h3C,  8'h0C,  0, 0, 0, 0, 0);
    issue(OR_,  8'h0F,  8'h3C,  8'h3F,  0, 0, 0, 0, 0);
    issue(NOR_, 8'h0F,  8'h3C,  8'hC0,  0, 1, 0, 0, 0);
    issue(XOR_, 8'h0F,  8'h3C,  8'h33,  0, 0, 0, 0, 0);

    idle(2);
    check("hold_out",       out,           8'h33);
    check("hold_out_valid", 8'(out_valid), 8'h00);

    issue(SRA,  8'h90,  8'd2,   8'hE4,  0, 1, 0, 0, 0);
    issue(SRL,  8'h90,  8'd2,   8'h24,  0, 0, 0, 0, 0);
    issue(SRL,  8'h90,  8'd9,   8'h00,  1, 0, 0, 0, 0);
    issue(SRA,  8'h90,  8'd200, 8'hFF,  0, 1, 0, 0, 0);
    issue(SRA,  8'h40,  8'd1,   8'h20,  0, 0, 0, 0, 0);
    issue(SRA,  8'h40,  8'd8,   8'h00,  1, 0, 0, 0, 0);
    issue(BAD,  8'h55,  8'hAA,  8'h00,  1, 0, 0, 0, 1);

    idle(2);
    check("hold_ill_out",       out,            8'h00);
    check("hold_ill_out_valid", 8'(out_valid),  8'h00);
    check("hold_ill_flag",      8'(illegal_op), 8'(fl(1'b1)));

    issue(ADD,  8'd3,   8'd4,   8'd7,   0, 0, 0, 0, 0);
    // Reset wins over a simultaneous valid request; nothing is expected from it.
    rst = 1'b1; in_valid = 1'b1; opcode = ADD; d0 = 8'd200; d1 = 8'd100;
    @(posedge clk); #1;
    check("rst_out",       out,             8'h00);
    check("rst_out_valid", 8'(out_valid),   8'h00);
    check("rst_carry",     8'(carry),       8'h00);
    check("rst_zero",      8'(zero),        8'h00);
    rst = 1'b0;

    issue(ADD,  8'd1,   8'd2,   8'd3,   0, 0, 0, 0, 0);
    idle(3);

    check("scoreboard_drained", 8'(q.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
